// File: rtl/ntt_pkg.sv
// Shared NTT constants for q = 3329: modulus, Barrett constants and datapath widths.
// Imported by barrett_reduce and modular_multiplication_pipe.
package ntt_pkg;

    localparam int DEFAULT_DATA_WIDTH = 12;
    localparam int DEFAULT_TAG_WIDTH  = 9;

    localparam logic [11:0] Q         = 12'd3329;
    localparam logic [12:0] BARRETT_M = 13'd5039;
    localparam int          BARRETT_K = 24;

    localparam int Q_WIDTH    = 12;
    localparam int PROD_WIDTH = 24;
    localparam int MUL_WIDTH  = 37;
    localparam int RED_WIDTH  = 14;

    // Folds a value known to be in [0, 2q) back into [0, q).
    function automatic logic [RED_WIDTH-1:0] cond_sub_q(input logic [RED_WIDTH-1:0] r);
        logic [RED_WIDTH-1:0] res;
        res = r;
        if (r >= RED_WIDTH'(Q)) begin
            res = r - RED_WIDTH'(Q);
        end
        return res;
    endfunction

endpackage

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a 24-bit product modulo q = 3329, exposed as two
// halves (quotient estimate, then remainder) so the parent can register between them.
module barrett_reduce
    import ntt_pkg::*;
(
    input  logic [PROD_WIDTH-1:0] p_s2,
    output logic [Q_WIDTH-1:0]    t_s2,
    input  logic [PROD_WIDTH-1:0] p_s3,
    input  logic [Q_WIDTH-1:0]    t_s3,
    output logic [Q_WIDTH-1:0]    r_s3
);

    logic [MUL_WIDTH-1:0] prod_m;
    logic [RED_WIDTH-1:0] r_raw;
    logic [RED_WIDTH-1:0] r_fix;

    // Quotient estimate: floor(p * m / 2^k) underestimates floor(p / q) by at most one.
    always_comb begin
        prod_m = MUL_WIDTH'(p_s2) * MUL_WIDTH'(BARRETT_M);
        t_s2   = Q_WIDTH'(prod_m >> BARRETT_K);
    end

    // The true remainder lies in [0, 2q) < 2^14, so 14-bit wrap-around arithmetic is exact.
    always_comb begin
        r_raw = RED_WIDTH'(p_s3) - RED_WIDTH'(RED_WIDTH'(t_s3) * RED_WIDTH'(Q));
        r_fix = cond_sub_q(r_raw);
        r_s3  = Q_WIDTH'(r_fix);
    end

endmodule

// File: rtl/modular_multiplication_pipe.sv
// Three-stage pipelined z = (a * w) mod 3329 with Barrett reduction and valid/ready flow.
// Optional sideband tag travelling with each operand pair: define MODMUL_TAG_EN.
module modular_multiplication_pipe
    import ntt_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] w,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] z
`ifdef MODMUL_TAG_EN
    ,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic [TAG_WIDTH-1:0]  tag_out
`endif
);

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high. The
    // three stages shift together whenever S3 is empty or being taken (adv); bubbles stay.
    logic adv;

    logic                  v1_q, v1_d;
    logic                  v2_q, v2_d;
    logic                  v3_q, v3_d;
    logic [PROD_WIDTH-1:0] p1_q, p1_d;
    logic [PROD_WIDTH-1:0] p2_q, p2_d;
    logic [Q_WIDTH-1:0]    t2_q, t2_d;
    logic [DATA_WIDTH-1:0] z_q,  z_d;

    logic [Q_WIDTH-1:0] t_s2;
    logic [Q_WIDTH-1:0] r_s3;

    barrett_reduce u_barrett (
        .p_s2 (p1_q),
        .t_s2 (t_s2),
        .p_s3 (p2_q),
        .t_s3 (t2_q),
        .r_s3 (r_s3)
    );

    always_comb begin
        adv  = ~v3_q | out_ready;
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        p1_d = p1_q;
        p2_d = p2_q;
        t2_d = t2_q;
        z_d  = z_q;
        if (adv) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            // Data registers only load when a valid beat enters them.
            if (in_valid) begin
                p1_d = PROD_WIDTH'(a) * PROD_WIDTH'(w);
            end
            if (v1_q) begin
                p2_d = p1_q;
                t2_d = t_s2;
            end
            if (v2_q) begin
                z_d = DATA_WIDTH'(r_s3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            p1_q <= '0;
            p2_q <= '0;
            t2_q <= '0;
            z_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            t2_q <= t2_d;
            z_q  <= z_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign z         = z_q;

`ifdef MODMUL_TAG_EN
    logic [TAG_WIDTH-1:0] tag1_q, tag1_d;
    logic [TAG_WIDTH-1:0] tag2_q, tag2_d;
    logic [TAG_WIDTH-1:0] tag3_q, tag3_d;

    // Tags follow exactly the same load enables as the data they describe.
    always_comb begin
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        tag3_d = tag3_q;
        if (adv) begin
            if (in_valid) begin
                tag1_d = tag_in;
            end
            if (v1_q) begin
                tag2_d = tag1_q;
            end
            if (v2_q) begin
                tag3_d = tag2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            tag3_q <= tag3_d;
        end
    end

    assign tag_out = tag3_q;
`else
    // No sideband path in this build; TAG_WIDTH is kept for a uniform parameter list.
`endif

endmodule

// File: tb/tb_modular_multiplication_pipe.sv
// Self-checking bench for modular_multiplication_pipe: corner-value table, latency,
// streaming, backpressure, mid-stream reset and (with MODMUL_TAG_EN) tag tracking.
module tb_modular_multiplication_pipe;

    localparam int DW = 12;
    localparam int TW = 9;
    localparam int QV = 3329;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] w;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] z;
`ifdef MODMUL_TAG_EN
    logic [TW-1:0] tag_in;
    logic [TW-1:0] tag_out;
`endif

    modular_multiplication_pipe #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
`ifdef MODMUL_TAG_EN
        ,
        .tag_in    (tag_in),
        .tag_out   (tag_out)
`endif
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int last_wait;

    logic [DW-1:0] exp_q[$];
    logic [TW-1:0] tag_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout/unexpected expected normal completion", name);
    endtask

    // Reference: plain modular arithmetic.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] av, input logic [DW-1:0] wv);
        int prod;
        prod = int'(av) * int'(wv);
        return DW'(prod % QV);
    endfunction

    logic          stall_prev;
    logic [DW-1:0] z_prev;
`ifdef MODMUL_TAG_EN
    logic [TW-1:0] tag_prev;
`endif

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_z", 32'(z), 32'(z_prev));
`ifdef MODMUL_TAG_EN
                check("hold_tag", 32'(tag_out), 32'(tag_prev));
`endif
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("z_out", 32'(z), 32'(e));
`ifdef MODMUL_TAG_EN
                    check("tag_out", 32'(tag_out), 32'(tag_q.pop_front()));
`else
                    void'(tag_q.pop_front());
`endif
                    n_out++;
                end
            end
            stall_prev = out_valid && !out_ready;
            z_prev     = z;
`ifdef MODMUL_TAG_EN
            tag_prev   = tag_out;
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the edge that captured the beat.
    task automatic drive_beat(input logic [DW-1:0] av, input logic [DW-1:0] wv,
                              input logic [DW-1:0] ze, input logic [TW-1:0] tg);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        a        = av;
        w        = wv;
`ifdef MODMUL_TAG_EN
        tag_in   = tg;
`endif
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        if (!in_ready) begin
            fail_now("accept_timeout");
        end else begin
            exp_q.push_back(ze);
            tag_q.push_back(tg);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] w;
        logic [DW-1:0] z;
    } vec_t;

    vec_t vecs[8];
    logic stall_done;

    // ---------------- main sequence ----------------
    initial begin
        int c;
        int base;
        int waits;
        logic [DW-1:0] ra, rw, first_exp;

        vecs[0] = '{12'd3328, 12'd3328, 12'd1};
        vecs[1] = '{12'd0,    12'd2917, 12'd0};
        vecs[2] = '{12'd17,   12'd17,   12'd289};
        vecs[3] = '{12'd3328, 12'd1,    12'd3328};
        vecs[4] = '{12'd1234, 12'd2000, 12'd1211};
        vecs[5] = '{12'd1664, 12'd2,    12'd3328};
        vecs[6] = '{12'd2,    12'd1665, 12'd1};
        vecs[7] = '{12'd3328, 12'd2,    12'd3327};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        w          = '0;
        stall_done = 1'b0;
        stall_prev = 1'b0;
`ifdef MODMUL_TAG_EN
        tag_in     = '0;
`endif

        // Reset values
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single beat latency: capture edge counts as edge 1
        drive_beat(12'd1234, 12'd2000, 12'd1211, 9'd0);
        c = 1;
        while (!out_valid && c < 10) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("latency_edges", 32'(c), 32'd3);
        check("single_z", 32'(z), 32'd1211);
        @(posedge clk);
        #1;
        check("single_valid_drop", 32'(out_valid), 32'd0);

        // Corner-value table, back-to-back
        for (int i = 0; i < 8; i++) begin
            check("table_model", 32'(model(vecs[i].a, vecs[i].w)), 32'(vecs[i].z));
            drive_beat(vecs[i].a, vecs[i].w, vecs[i].z, TW'(i));
        end
        wait_drain(10);

        // Streaming 1000 random pairs with out_ready high
        base  = n_out;
        waits = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = DW'($urandom_range(0, QV - 1));
            rw = DW'($urandom_range(0, QV - 1));
            drive_beat(ra, rw, model(ra, rw), TW'(i));
            waits += last_wait;
        end
        check("stream_in_ready_stalls", 32'(waits), 32'd0);
        wait_drain(3);
        check("stream_count", 32'(n_out - base), 32'd1000);

        // Backpressure: three beats under out_ready low, fourth waits, then release
        base      = n_out;
        out_ready = 1'b0;
        ra        = DW'($urandom_range(0, QV - 1));
        rw        = DW'($urandom_range(0, QV - 1));
        first_exp = model(ra, rw);
        drive_beat(ra, rw, first_exp, 9'd100);
        for (int i = 1; i < 3; i++) begin
            ra = DW'($urandom_range(0, QV - 1));
            rw = DW'($urandom_range(0, QV - 1));
            drive_beat(ra, rw, model(ra, rw), TW'(100 + i));
        end
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_first_z", 32'(z), 32'(first_exp));
        repeat (4) @(posedge clk);
        #1;
        check("bp_still_blocked", 32'(in_ready), 32'd0);
        ra = DW'($urandom_range(0, QV - 1));
        rw = DW'($urandom_range(0, QV - 1));
        fork
            drive_beat(ra, rw, model(ra, rw), 9'd103);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain(10);
        check("bp_count", 32'(n_out - base), 32'd4);

        // Reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = DW'($urandom_range(0, QV - 1));
            rw = DW'($urandom_range(0, QV - 1));
            drive_beat(ra, rw, model(ra, rw), TW'(200 + i));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_z", 32'(z), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        tag_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = n_out;
        ra   = DW'($urandom_range(0, QV - 1));
        rw   = DW'($urandom_range(0, QV - 1));
        drive_beat(ra, rw, model(ra, rw), 9'd300);
        wait_drain(10);
        check("midrst_count", 32'(n_out - base), 32'd1);

        // Random stalls with tags 0..511
        base = n_out;
        fork
            begin
                for (int i = 0; i < 512; i++) begin
                    ra = DW'($urandom_range(0, QV - 1));
                    rw = DW'($urandom_range(0, QV - 1));
                    drive_beat(ra, rw, model(ra, rw), TW'(i));
                end
                stall_done = 1'b1;
            end
            begin
                while (!stall_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(20);
        check("stall_count", 32'(n_out - base), 32'd512);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
